text_scroll_cursor: RTL
=======================

# text_scroll_cursor

Parametrised address and overlay front end for the text-mode VGA pipeline. It sits between the VGA timing engine's pixel coordinates and the character RAM / font ROM stages. It maps screen pixels to character RAM addresses through a circular hardware-scroll offset, and delays glyph coordinates to align with character data. It also generates a blinking, shape-programmable hardware cursor overlay, controlled through a small single-clock register file that takes effect only at vertical blank.

## Interface
- FONT_W, 8: glyph width in pixels; power of two.
- FONT_H, 16: glyph height in pixels; power of two.
- N_COL, 80: text columns.
- N_ROW, 30: text rows.
- H_BITS, 10: horizontal coordinate width.
- V_BITS, 9: vertical coordinate width.
- ADDR_W, 12: character RAM address width; N_COL*N_ROW ≤ 2^ADDR_W.
- DATA_LAT, 1: character RAM read latency in cycles.

Ports:
- pixel_clk  in  1  sole clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- horizPos  in  H_BITS  current pixel x from timing engine.
- vertPos  in  V_BITS  current pixel y.
- vBlank  in  1  vertical blanking flag.
- reg_addr  in  3  register select.
- reg_we  in  1  register write strobe, one cycle per write.
- reg_dataIn  in  16  write data.
- reg_dataOut  out  16  registered read data.
- char_addr  out  ADDR_W  character RAM video-port address.
- glyph_h  out  log2(FONT_W)  pixel column within glyph, aligned to char data.
- glyph_v  out  log2(FONT_H)  pixel row within glyph, aligned to char data.
- cursor_hit  out  1  pixel lies in the visible cursor; aligned to glyph_h/glyph_v.
- blink_phase  out  1  current blink state.

## Operation
- Registers hold shadow (CPU-visible) and active (video-visible) copies. Writes go to shadow; all shadows copy to active on the vBlank rising edge (vBlank high, previous cycle low).
  - 0 CURSOR_X [6:0]: cursor column.
  - 1 CURSOR_Y [4:0]: cursor logical (on-screen) row.
  - 2 SCROLL [4:0]: physical row displayed at screen top. Writes ≥ N_ROW are ignored; shadow keeps its old value.
  - 3 CTRL: bit0 cursor enable, bit1 blink enable, [7:4] cursor start line, [11:8] cursor end line.
  - 4 BLINK_PERIOD [7:0]: frames per blink half-period; 0 behaves as 1.
  - 5 STATUS (read-only; writes ignored): bit0 vBlank, bit1 blink_phase, [15:8] frame counter (wraps at 256).
  - 6, 7: read 0, writes ignored.
- Unused read bits return 0. reg_dataOut updates every cycle from reg_addr.
- Address path:
  - col = horizPos / FONT_W; lrow = vertPos / FONT_H.
  - prow = lrow + SCROLL, minus N_ROW if ≥ N_ROW (single conditional subtract).
  - char_addr = prow*N_COL + col.
  - Coordinates beyond the text area produce don't-care addresses; no clamping is required.
- Blink and frame counters:
  - Frame counter increments on each vBlank rising edge.
  - The blink counter also increments on each vBlank rising edge. On reaching BLINK_PERIOD−1, it clears and blink_phase toggles.
  - With blink disabled, blink_phase is forced 1 and the counter is held at 0.
- cursor_hit = enable & blink_phase & (lrow == CURSOR_Y) & (col == CURSOR_X) & start ≤ glyph_v ≤ end.
  - If start > end, or the cursor lies outside N_COL×N_ROW, cursor_hit is never asserted.
  - The cursor tracks logical rows, so it is unaffected by SCROLL.

## Timing
- char_addr is registered 2 cycles after horizPos/vertPos: stage 1 computes col, lrow, prow; stage 2 computes the address.
- glyph_h, glyph_v and cursor_hit appear 2+DATA_LAT cycles after the input coordinates, in the same cycle the character RAM data is valid.
- Register write: shadow updates on the clock edge where reg_we=1. A read of the same address shows the new value one cycle later.
- Active copies change only on a vBlank rising edge.
  - A write in the same cycle as that edge is included in the transfer.
  - Writes while vBlank is held high take effect at the next frame's edge.
- Reset values:
  - CURSOR_X, CURSOR_Y, SCROLL = 0; CTRL = 0x0FE3; BLINK_PERIOD = 16. Shadow and active copies are equal.
  - Counters = 0; blink_phase = 1.
  - All pipeline outputs and reg_dataOut = 0.
- Reset asserted mid-frame returns everything to these values immediately. The first post-reset vBlank edge re-transfers the reset values.

## Test plan
- Reset, hold 3 cycles, release → CTRL read 0x0FE3, BLINK_PERIOD read 16, blink_phase=1, char_addr=0.
- SCROLL=0; drive x=17, y=35 → 2 cycles later char_addr=2*80+2=162; at 3 cycles glyph_h=1, glyph_v=3.
- Write SCROLL=29 mid-frame → char_addr unchanged until vBlank edge. After the edge, y=16,x=0 gives char_addr=(1+29−30)*80=0. A write of SCROLL=30 reads back 29.
- Cursor X=5,Y=2, CTRL=0x0F01 (blink off, lines 0–15) → cursor_hit=1 exactly for x∈[40,47], y∈[32,47], 3 cycles delayed; for start=9,end=3 → never.
- BLINK_PERIOD=2, blink on → blink_phase toggles every 2 vBlank edges. cursor_hit is suppressed while phase=0. STATUS[15:8] counts edges.
- Write CTRL in the same cycle as the vBlank rising edge → the new value is active that frame.

Source files
------------

// File: rtl/text_scroll_cursor_if.sv
// Register bus between the host and text_scroll_cursor.
//   reg_addr    : register select (0..7)
//   reg_we      : single-cycle write strobe
//   reg_dataIn  : write data
//   reg_dataOut : registered read data of reg_addr
interface text_scroll_cursor_if;
  logic [2:0]  reg_addr;
  logic        reg_we;
  logic [15:0] reg_dataIn;
  logic [15:0] reg_dataOut;

  modport master (output reg_addr, reg_we, reg_dataIn, input reg_dataOut);
  modport slave  (input reg_addr, reg_we, reg_dataIn, output reg_dataOut);
endinterface

// File: rtl/text_scroll_cursor.sv
// Text-mode address/overlay front end: maps pixel coordinates to character
// RAM addresses through a circular scroll offset, delays glyph coordinates to
// line up with character data, and produces a blinking hardware cursor.
// Register shadows are CPU-visible; actives are loaded on vBlank rising edge.
// Ports:
//   pixel_clk, rst_n     : clock, async active-low reset
//   horizPos, vertPos    : pixel coordinates from the timing engine
//   vBlank               : vertical blanking flag
//   regs                 : register bus (slave)
//   char_addr            : character RAM address, 2 cycles after coordinates
//   glyph_h, glyph_v     : pixel within glyph, 2+DATA_LAT cycles after
//   cursor_hit           : pixel inside visible cursor, aligned to glyph_*
//   blink_phase          : current blink state
module text_scroll_cursor #(
  parameter int unsigned FONT_W   = 8,
  parameter int unsigned FONT_H   = 16,
  parameter int unsigned N_COL    = 80,
  parameter int unsigned N_ROW    = 30,
  parameter int unsigned H_BITS   = 10,
  parameter int unsigned V_BITS   = 9,
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned DATA_LAT = 1
) (
  input  logic                       pixel_clk,
  input  logic                       rst_n,
  input  logic [H_BITS-1:0]          horizPos,
  input  logic [V_BITS-1:0]          vertPos,
  input  logic                       vBlank,
  text_scroll_cursor_if.slave        regs,
  output logic [ADDR_W-1:0]          char_addr,
  output logic [$clog2(FONT_W)-1:0]  glyph_h,
  output logic [$clog2(FONT_H)-1:0]  glyph_v,
  output logic                       cursor_hit,
  output logic                       blink_phase
);

  localparam int unsigned GH_W   = $clog2(FONT_W);
  localparam int unsigned GV_W   = $clog2(FONT_H);
  localparam int unsigned COL_W  = H_BITS - GH_W;
  localparam int unsigned ROW_W  = V_BITS - GV_W;
  localparam int unsigned PROW_W = ROW_W + 1;

  // Register file: shadow (_s), next shadow (_nxt), active (_a)
  logic [6:0] cx_s, cx_nxt, cx_a;
  logic [4:0] cy_s, cy_nxt, cy_a;
  logic [4:0] scr_s, scr_nxt, scr_a;
  logic       cen_s, cen_nxt, cen_a;
  logic       ben_s, ben_nxt, ben_a;
  logic [3:0] cst_s, cst_nxt, cst_a;
  logic [3:0] cend_s, cend_nxt, cend_a;
  logic [7:0] bp_s, bp_nxt, bp_a;

  logic       vb_q;
  logic       vb_edge;
  logic [7:0] frame_cnt;
  logic [7:0] blink_cnt;
  logic [7:0] bp_m1;

  // Bits of the write bus that no register stores
  logic unused_bits;
  assign unused_bits = ^{regs.reg_dataIn[15:12], regs.reg_dataIn[3:2]};

  assign vb_edge = vBlank & ~vb_q;

  // Shadow next-state: the same-cycle write is visible to a vBlank transfer
  always_comb begin
    cx_nxt   = cx_s;
    cy_nxt   = cy_s;
    scr_nxt  = scr_s;
    cen_nxt  = cen_s;
    ben_nxt  = ben_s;
    cst_nxt  = cst_s;
    cend_nxt = cend_s;
    bp_nxt   = bp_s;
    if (regs.reg_we) begin
      case (regs.reg_addr)
        3'd0: cx_nxt = regs.reg_dataIn[6:0];
        3'd1: cy_nxt = regs.reg_dataIn[4:0];
        3'd2: if (32'(regs.reg_dataIn[4:0]) < N_ROW) scr_nxt = regs.reg_dataIn[4:0];
        3'd3: begin
          cen_nxt  = regs.reg_dataIn[0];
          ben_nxt  = regs.reg_dataIn[1];
          cst_nxt  = regs.reg_dataIn[7:4];
          cend_nxt = regs.reg_dataIn[11:8];
        end
        3'd4: bp_nxt = regs.reg_dataIn[7:0];
        default: ;
      endcase
    end
  end

  // Shadow and active register copies
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      vb_q   <= 1'b0;
      cx_s   <= '0;    cx_a   <= '0;
      cy_s   <= '0;    cy_a   <= '0;
      scr_s  <= '0;    scr_a  <= '0;
      cen_s  <= 1'b1;  cen_a  <= 1'b1;
      ben_s  <= 1'b1;  ben_a  <= 1'b1;
      cst_s  <= 4'hE;  cst_a  <= 4'hE;
      cend_s <= 4'hF;  cend_a <= 4'hF;
      bp_s   <= 8'd16; bp_a   <= 8'd16;
    end else begin
      vb_q   <= vBlank;
      cx_s   <= cx_nxt;
      cy_s   <= cy_nxt;
      scr_s  <= scr_nxt;
      cen_s  <= cen_nxt;
      ben_s  <= ben_nxt;
      cst_s  <= cst_nxt;
      cend_s <= cend_nxt;
      bp_s   <= bp_nxt;
      if (vb_edge) begin
        cx_a   <= cx_nxt;
        cy_a   <= cy_nxt;
        scr_a  <= scr_nxt;
        cen_a  <= cen_nxt;
        ben_a  <= ben_nxt;
        cst_a  <= cst_nxt;
        cend_a <= cend_nxt;
        bp_a   <= bp_nxt;
      end
    end
  end

  // A period of 0 behaves like 1, so its terminal count is 0 either way
  assign bp_m1 = (bp_a == 8'd0) ? 8'd0 : bp_a - 8'd1;

  // Frame and blink counters; blink uses the settings active before this edge
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt   <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else begin
      if (vb_edge) frame_cnt <= frame_cnt + 8'd1;
      if (!ben_a) begin
        blink_cnt   <= '0;
        blink_phase <= 1'b1;
      end else if (vb_edge) begin
        if (blink_cnt >= bp_m1) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 8'd1;
        end
      end
    end
  end

  // Registered read-back of the shadow copies
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      regs.reg_dataOut <= '0;
    end else begin
      case (regs.reg_addr)
        3'd0:    regs.reg_dataOut <= {9'd0, cx_s};
        3'd1:    regs.reg_dataOut <= {11'd0, cy_s};
        3'd2:    regs.reg_dataOut <= {11'd0, scr_s};
        3'd3:    regs.reg_dataOut <= {4'd0, cend_s, cst_s, 2'd0, ben_s, cen_s};
        3'd4:    regs.reg_dataOut <= {8'd0, bp_s};
        3'd5:    regs.reg_dataOut <= {frame_cnt, 6'd0, blink_phase, vBlank};
        default: regs.reg_dataOut <= '0;
      endcase
    end
  end

  // Stage 1 combinational: cell coordinates, scrolled row, cursor match
  logic [COL_W-1:0]  col_w;
  logic [ROW_W-1:0]  lrow_w;
  logic [GH_W-1:0]   gh_w;
  logic [GV_W-1:0]   gv_w;
  logic [PROW_W-1:0] prow_sum;
  logic [PROW_W-1:0] prow_w;
  logic              hit_w;

  assign col_w    = horizPos[H_BITS-1:GH_W];
  assign lrow_w   = vertPos[V_BITS-1:GV_W];
  assign gh_w     = horizPos[GH_W-1:0];
  assign gv_w     = vertPos[GV_W-1:0];
  assign prow_sum = PROW_W'(lrow_w) + PROW_W'(scr_a);
  // Single conditional subtract: scroll < N_ROW keeps on-screen rows in range
  assign prow_w   = (32'(prow_sum) >= N_ROW) ? prow_sum - PROW_W'(N_ROW) : prow_sum;
  // Cursor compares logical rows so scrolling does not move it
  assign hit_w    = cen_a & blink_phase
                  & (32'(lrow_w) == 32'(cy_a)) & (32'(col_w) == 32'(cx_a))
                  & (32'(cst_a) <= 32'(gv_w)) & (32'(gv_w) <= 32'(cend_a))
                  & (32'(cx_a) < N_COL) & (32'(cy_a) < N_ROW);

  logic [COL_W-1:0]  col_q;
  logic [PROW_W-1:0] prow_q;
  logic [GH_W-1:0]   gh_q;
  logic [GV_W-1:0]   gv_q;
  logic              hit_q;

  // Index 0 is stage 2; index DATA_LAT lines up with character RAM data
  logic [GH_W-1:0] gh_d  [0:DATA_LAT];
  logic [GV_W-1:0] gv_d  [0:DATA_LAT];
  logic            hit_d [0:DATA_LAT];

  // Address pipeline and glyph/cursor alignment delay
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q     <= '0;
      prow_q    <= '0;
      gh_q      <= '0;
      gv_q      <= '0;
      hit_q     <= 1'b0;
      char_addr <= '0;
      for (int unsigned k = 0; k <= DATA_LAT; k++) begin
        gh_d[k]  <= '0;
        gv_d[k]  <= '0;
        hit_d[k] <= 1'b0;
      end
    end else begin
      col_q     <= col_w;
      prow_q    <= prow_w;
      gh_q      <= gh_w;
      gv_q      <= gv_w;
      hit_q     <= hit_w;
      char_addr <= ADDR_W'(32'(prow_q) * N_COL + 32'(col_q));
      gh_d[0]   <= gh_q;
      gv_d[0]   <= gv_q;
      hit_d[0]  <= hit_q;
      for (int unsigned k = 1; k <= DATA_LAT; k++) begin
        gh_d[k]  <= gh_d[k-1];
        gv_d[k]  <= gv_d[k-1];
        hit_d[k] <= hit_d[k-1];
      end
    end
  end

  assign glyph_h    = gh_d[DATA_LAT];
  assign glyph_v    = gv_d[DATA_LAT];
  assign cursor_hit = hit_d[DATA_LAT];

endmodule
